// File: rtl/spmv_csr_engine.sv
// CSR sparse-matrix x dense-vector engine: walks row pointers, nonzeros and x,
// emitting one signed row sum per valid/ready beat and flagging malformed CSR data.
module spmv_csr_engine #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned MAX_ROWS = 16,
  parameter int unsigned MAX_COLS = 16,
  parameter int unsigned MAX_NNZ  = 256,
  localparam int unsigned RW = $clog2(MAX_ROWS + 1),
  localparam int unsigned CW = $clog2(MAX_COLS),
  localparam int unsigned NW = $clog2(MAX_NNZ + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [RW-1:0]     i_num_rows,
  input  logic [CW:0]       i_num_cols,
  output logic [RW-1:0]     o_rp_addr,
  input  logic [NW-1:0]     i_rp_data,
  output logic [NW-1:0]     o_nz_addr,
  input  logic [CW:0]       i_col_idx,
  input  logic [DATA_W-1:0] i_val,
  output logic [CW-1:0]     o_x_addr,
  input  logic [DATA_W-1:0] i_x_data,
  output logic              o_y_valid,
  input  logic              i_y_ready,
  output logic [RW-1:0]     o_y_row,
  output logic [ACC_W-1:0]  o_y_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned PW = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_RP_FIRST, S_RP_NEXT, S_NZ, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                rp_phase_q, rp_phase_d;
  logic [RW-1:0]       r_q, r_d;
  logic [RW-1:0]       nrows_q, nrows_d;
  logic [CW:0]         ncols_q, ncols_d;
  logic [NW-1:0]       beg_q, beg_d;
  logic [NW-1:0]       end_q, end_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [DATA_W-1:0]   val1_q, val1_d, val2_q, val2_d;
  logic                bad1_q, bad1_d, bad2_q, bad2_d;
  logic [RW-1:0]       rp_addr_d;
  logic [NW-1:0]       nz_addr_d;
  logic [CW-1:0]       x_addr_d;
  logic                valid_d, busy_d, done_d, err_d;
  logic signed [PW-1:0] prod;

  assign o_y_row  = r_q;
  assign o_y_data = acc_q;
  assign prod     = PW'($signed(val2_q)) * PW'($signed(i_x_data));

  // Next-state, datapath and output-register values
  always_comb begin
    state_d    = state_q;
    rp_phase_d = rp_phase_q;
    r_d        = r_q;
    nrows_d    = nrows_q;
    ncols_d    = ncols_q;
    beg_d      = beg_q;
    end_d      = end_q;
    acc_d      = acc_q;
    rp_addr_d  = o_rp_addr;
    nz_addr_d  = o_nz_addr;
    x_addr_d   = o_x_addr;
    valid_d    = o_y_valid;
    err_d      = o_err;
    done_d     = 1'b0;
    val1_d     = val1_q;
    bad1_d     = bad1_q;
    v1_d       = (state_q == S_NZ);
    v2_d       = v1_q;
    v3_d       = v2_q;
    val2_d     = val1_q;
    bad2_d     = bad1_q;

    // Stage 1: col/val arrive; out-of-range columns keep x_addr and zero the term
    if (v1_q) begin
      val1_d = i_val;
      bad1_d = (i_col_idx >= ncols_q);
      if (i_col_idx >= ncols_q) err_d = 1'b1;
      else                      x_addr_d = i_col_idx[CW-1:0];
    end

    if (v3_q && !bad2_q) acc_d = acc_q + ACC_W'(prod);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          nrows_d   = i_num_rows;
          ncols_d   = i_num_cols;
          err_d     = 1'b0;
          r_d       = '0;
          acc_d     = '0;
          rp_addr_d = '0;
          if (i_num_rows == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RP_FIRST;
          end
        end
      end
      S_RP_FIRST: begin
        rp_addr_d  = RW'(1);
        rp_phase_d = 1'b0;
        state_d    = S_RP_NEXT;
      end
      S_RP_NEXT: begin
        if (!rp_phase_q) begin
          if (r_q == '0) beg_d = i_rp_data;
          rp_phase_d = 1'b1;
        end else begin
          end_d      = i_rp_data;
          rp_phase_d = 1'b0;
          if (i_rp_data > beg_q) begin
            nz_addr_d = beg_q;
            state_d   = S_NZ;
          end else begin
            if (i_rp_data < beg_q) err_d = 1'b1;
            valid_d = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_NZ: begin
        if (o_nz_addr == end_q - NW'(1)) state_d = S_DRAIN;
        else                             nz_addr_d = o_nz_addr + NW'(1);
      end
      S_DRAIN: begin
        if (v3_q && !v2_q && !v1_q) begin
          valid_d = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_y_ready) begin
          valid_d = 1'b0;
          acc_d   = '0;
          r_d     = r_q + RW'(1);
          if ((r_q + RW'(1)) == nrows_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            beg_d      = end_q;
            rp_addr_d  = r_q + RW'(2);
            rp_phase_d = 1'b0;
            state_d    = S_RP_NEXT;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rp_phase_q <= 1'b0;
      r_q        <= '0;
      nrows_q    <= '0;
      ncols_q    <= '0;
      beg_q      <= '0;
      end_q      <= '0;
      acc_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      val1_q     <= '0;
      val2_q     <= '0;
      bad1_q     <= 1'b0;
      bad2_q     <= 1'b0;
      o_rp_addr  <= '0;
      o_nz_addr  <= '0;
      o_x_addr   <= '0;
      o_y_valid  <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rp_phase_q <= rp_phase_d;
      r_q        <= r_d;
      nrows_q    <= nrows_d;
      ncols_q    <= ncols_d;
      beg_q      <= beg_d;
      end_q      <= end_d;
      acc_q      <= acc_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      val1_q     <= val1_d;
      val2_q     <= val2_d;
      bad1_q     <= bad1_d;
      bad2_q     <= bad2_d;
      o_rp_addr  <= rp_addr_d;
      o_nz_addr  <= nz_addr_d;
      o_x_addr   <= x_addr_d;
      o_y_valid  <= valid_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_err      <= err_d;
    end
  end

endmodule
